lvds_serializer: RTL and testbench
==================================

// Module: lvds_serializer
// PURPOSE
//  TX-side parallel-to-serial stage feeding lvds_deserializer (same clk_serial domain).
//  Accepts PARALLEL_WIDTH-bit words over a valid/ready handshake and buffers them.
//  Per word: emits a 1-cycle tx_frame_pulse, then shifts the word MSB-first on a
//  differential pair (tx_lvds_out_p/_n), one bit per clk_serial cycle.
// PARAMETERS
//  PARALLEL_WIDTH  8   word width; must match the deserializer; >=2
//  FIFO_DEPTH      4   input FIFO entries (power of 2, >=2); used only with LVDS_SER_FIFO_EN
//  CNT_WIDTH       16  width of frame_count
// PORTS
//  clk_serial      in   1               fast serial clock; all logic on posedge
//  reset_n         in   1               asynchronous, active-low reset
//  s_data          in   PARALLEL_WIDTH  word to serialize
//  s_valid         in   1               s_data valid
//  s_ready         out  1               buffer can accept; transfer = s_valid & s_ready
//  tx_frame_pulse  out  1               1-cycle pulse; frame bits start the next cycle
//  tx_lvds_out_p   out  1               serial data, true
//  tx_lvds_out_n   out  1               serial data, complement (always ~p)
//  ser_busy        out  1               high from pulse cycle through last bit cycle
//  frame_count     out  CNT_WIDTH       completed frames, wraps to 0
// BEHAVIOUR
//  Reset values: s_ready=0 for the reset cycle, then 1; tx_frame_pulse=0; p=0; n=1;
//   ser_busy=0; frame_count=0; buffer empty; FSM=IDLE. All outputs registered except s_ready.
//  Reset mid-frame: frame abandoned immediately, buffered words discarded, no count.
//  FSM: IDLE -> START when buffer non-empty; START (1 cycle): pop word into shift reg,
//   tx_frame_pulse=1, p=0 -> SHIFT; SHIFT (PARALLEL_WIDTH cycles): p=shift[MSB], shift left,
//   bit counter PARALLEL_WIDTH-1 down to 0; at 0 -> GAP; GAP (1 cycle): p=0,
//   frame_count+1 -> START if buffer non-empty else IDLE.
//  Timing: pulse at cycle T0, bit W-1 at T1 ... bit 0 at TW, gap TW+1, next pulse
//   earliest TW+2. Min frame period PARALLEL_WIDTH+2 cycles. The gap is required because
//   the deserializer ignores a pulse coinciding with its last bit.
//  Latency: word accepted in cycle t into empty buffer, FSM IDLE -> pulse in cycle t+1.
//  Outside SHIFT: p=0, n=1. ser_busy=1 in START and SHIFT only.
//  Buffer (no FIFO): one holding register; s_ready = ~full; a pop and push in the same
//   cycle is allowed (s_ready=1 when full and START pops this cycle).
//  Simultaneous push/pop on empty buffer: the word is stored, not bypassed.
//  s_data is sampled only on transfer; s_valid without s_ready has no effect.
//  frame_count wraps (2^CNT_WIDTH-1)+1 -> 0 without flag.
// CONFIGURATION
//  `LVDS_SER_FIFO_EN defined: buffer is FIFO_DEPTH-entry circular FIFO (wr/rd pointers
//   with extra wrap bit); s_ready = ~full | pop; order preserved; full/empty exact at wrap.
//  Not defined: single holding register as above; FIFO_DEPTH ignored.
//  Serial timing identical in both builds.
// TESTING
//  1) Reset, push 8'hA5 -> pulse 1 cycle later; p = 1,0,1,0,0,1,0,1; n=~p; frame_count=1.
//  2) Loopback to lvds_deserializer, push 8'h3C,8'hFF,8'h00 back-to-back -> rx words
//     3C,FF,00 in order; pulses PARALLEL_WIDTH+2=10 cycles apart.
//  3) Hold s_valid=1 continuously -> s_ready drops when full (after 1 word no-FIFO,
//     4 words FIFO); no word lost or duplicated over 100 random words.
//  4) Assert reset_n=0 on bit 3 of a frame -> p=0,n=1,ser_busy=0 immediately;
//     frame_count unchanged; next frame after release is complete.
//  5) Preload frame_count to 16'hFFFF -> after next frame reads 16'h0000.
//  6) Idle 20 cycles with s_valid=0 -> no pulse, p=0, n=1, ser_busy=0 throughout.

Source files
------------

// File: rtl/lvds_serializer_if.sv
// Word handshake between the TX-side word source and lvds_serializer.
interface lvds_serializer_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/lvds_serializer.sv
// Parallel-to-serial LVDS TX stage: frame pulse, then MSB-first bits, then a one-cycle gap.
// `LVDS_SER_FIFO_EN selects a FIFO_DEPTH-entry input FIFO instead of a single holding register.
module lvds_serializer #(
  parameter int unsigned PARALLEL_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                 clk_serial,
  input  logic                 reset_n,
  lvds_serializer_if.slave     s_if,
  output logic                 tx_frame_pulse,
  output logic                 tx_lvds_out_p,
  output logic                 tx_lvds_out_n,
  output logic                 ser_busy,
  output logic [CNT_WIDTH-1:0] frame_count
);

  localparam int unsigned W     = PARALLEL_WIDTH;
  localparam int unsigned BIT_W = $clog2(W);

  if (PARALLEL_WIDTH < 2) begin : g_bad_width
    $error("lvds_serializer: PARALLEL_WIDTH must be >= 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("lvds_serializer: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  typedef enum logic [1:0] {IDLE, START, SHIFT, GAP} state_t;

  state_t               r_state, w_state_nxt;
  logic [W-1:0]         r_shift, w_shift_nxt;
  logic [BIT_W-1:0]     r_bit, w_bit_nxt;
  logic [CNT_WIDTH-1:0] r_frame_cnt, w_frame_cnt_nxt;
  logic                 r_pulse, w_pulse_nxt;
  logic                 r_p, w_p_nxt;
  logic                 r_n;
  logic                 r_busy, w_busy_nxt;
  logic                 r_rdy_en;
  logic                 w_push, w_pop, w_empty, w_full;
  logic [W-1:0]         w_head;

  // START always consumes the head word, so a full buffer can still take a word that cycle
  assign w_pop       = (r_state == START);
  assign s_if.s_ready = r_rdy_en & (~w_full | w_pop);
  assign w_push      = s_if.s_valid & s_if.s_ready;

`ifdef LVDS_SER_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]  r_wr_ptr, r_rd_ptr;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk_serial or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_serial) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= s_if.s_data;
  end
`else
  logic [W-1:0] r_hold;
  logic         r_full;

  assign w_empty = ~r_full;
  assign w_full  = r_full;
  assign w_head  = r_hold;

  always_ff @(posedge clk_serial or negedge reset_n) begin
    if (!reset_n) begin
      r_full <= 1'b0;
      r_hold <= '0;
    end else begin
      r_full <= w_push | (r_full & ~w_pop);
      if (w_push) r_hold <= s_if.s_data;
    end
  end
`endif

  // State register; outputs are registered from their next-cycle values
  always_ff @(posedge clk_serial or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bit       <= '0;
      r_frame_cnt <= '0;
      r_pulse     <= 1'b0;
      r_p         <= 1'b0;
      r_n         <= 1'b1;
      r_busy      <= 1'b0;
      r_rdy_en    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_bit       <= w_bit_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_pulse     <= w_pulse_nxt;
      r_p         <= w_p_nxt;
      r_n         <= ~w_p_nxt;
      r_busy      <= w_busy_nxt;
      r_rdy_en    <= 1'b1;
    end
  end

  // A word arriving this cycle counts as pending so the pulse follows acceptance by one cycle
  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_bit_nxt       = r_bit;
    w_frame_cnt_nxt = r_frame_cnt;
    w_pulse_nxt     = 1'b0;
    w_p_nxt         = 1'b0;
    w_busy_nxt      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty || w_push) begin
          w_state_nxt = START;
          w_pulse_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end
      START: begin
        w_shift_nxt = {w_head[W-2:0], 1'b0};
        w_p_nxt     = w_head[W-1];
        w_bit_nxt   = BIT_W'(W - 1);
        w_busy_nxt  = 1'b1;
        w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (r_bit == '0) begin
          w_state_nxt     = GAP;
          w_frame_cnt_nxt = r_frame_cnt + CNT_WIDTH'(1);
        end else begin
          w_p_nxt     = r_shift[W-1];
          w_shift_nxt = {r_shift[W-2:0], 1'b0};
          w_bit_nxt   = r_bit - BIT_W'(1);
          w_busy_nxt  = 1'b1;
        end
      end
      GAP: begin
        if (!w_empty || w_push) begin
          w_state_nxt = START;
          w_pulse_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign tx_frame_pulse = r_pulse;
  assign tx_lvds_out_p  = r_p;
  assign tx_lvds_out_n  = r_n;
  assign ser_busy       = r_busy;
  assign frame_count    = r_frame_cnt;

endmodule

// File: tb/tb_lvds_serializer.sv
// Scoreboard bench for lvds_serializer: the monitor deserializes the line and checks against queued words.
module tb_lvds_serializer;

  localparam int unsigned W   = 8;
  localparam int unsigned CW  = 16;
  localparam int unsigned WCW = 3;
`ifdef LVDS_SER_FIFO_EN
  localparam int unsigned BUF_DEPTH = 4;
`else
  localparam int unsigned BUF_DEPTH = 1;
`endif

  logic clk_serial = 1'b0;
  logic reset_n    = 1'b0;
  always #5 clk_serial = ~clk_serial;

  lvds_serializer_if #(.DATA_W(W)) s_if ();
  lvds_serializer_if #(.DATA_W(W)) s_if_w ();

  logic          pulse, p, n, busy;
  logic [CW-1:0] fc;
  logic          pulse_w, p_w, n_w, busy_w;
  logic [WCW-1:0] fc_w;

  lvds_serializer #(.PARALLEL_WIDTH(W), .FIFO_DEPTH(4), .CNT_WIDTH(CW)) dut (
    .clk_serial     (clk_serial),
    .reset_n        (reset_n),
    .s_if           (s_if),
    .tx_frame_pulse (pulse),
    .tx_lvds_out_p  (p),
    .tx_lvds_out_n  (n),
    .ser_busy       (busy),
    .frame_count    (fc)
  );

  // Narrow frame counter instance so the wrap is reachable in a short run
  lvds_serializer #(.PARALLEL_WIDTH(W), .FIFO_DEPTH(4), .CNT_WIDTH(WCW)) dut_w (
    .clk_serial     (clk_serial),
    .reset_n        (reset_n),
    .s_if           (s_if_w),
    .tx_frame_pulse (pulse_w),
    .tx_lvds_out_p  (p_w),
    .tx_lvds_out_n  (n_w),
    .ser_busy       (busy_w),
    .frame_count    (fc_w)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int last_xfer = 0;
  logic [W-1:0] exp_q [$];
  int           pulse_cyc [$];
  bit           cap = 1'b0;
  int           bitn = 0;
  logic [W-1:0] word = '0;

  always @(posedge clk_serial) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: acts as the receiving deserializer and checks line levels every cycle
  always @(negedge clk_serial) begin
    if (!reset_n) begin
      cap = 1'b0;
    end else if (cap) begin
      chk("n_is_not_p", 32'(n), 32'(!p));
      chk("busy_in_frame", 32'(busy), 32'd1);
      chk("pulse_in_frame", 32'(pulse), 32'd0);
      word = {word[W-2:0], p};
      bitn++;
      if (bitn == W) begin
        cap = 1'b0;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_underflow: got word %0h with no word expected", word);
        end else begin
          chk("rx_word", 32'(word), 32'(exp_q.pop_front()));
        end
      end
    end else if (pulse) begin
      chk("busy_at_pulse", 32'(busy), 32'd1);
      chk("p_at_pulse", 32'(p), 32'd0);
      cap  = 1'b1;
      bitn = 0;
      word = '0;
      pulse_cyc.push_back(cyc);
    end else begin
      chk("p_idle", 32'(p), 32'd0);
      chk("n_idle", 32'(n), 32'd1);
      chk("busy_idle", 32'(busy), 32'd0);
    end
  end

  // Called at a negedge; returns at the negedge after the transfer edge
  task automatic send(input logic [W-1:0] w);
    int k = 0;
    s_if.s_data  = w;
    s_if.s_valid = 1'b1;
    while (!s_if.s_ready && k < 4 * W) begin
      @(negedge clk_serial);
      k++;
    end
    if (!s_if.s_ready) begin
      chk("send_timeout", 32'(s_if.s_ready), 32'd1);
    end else begin
      exp_q.push_back(w);
      last_xfer = cyc;
    end
    @(negedge clk_serial);
    s_if.s_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || cap || busy) && k < 200) begin
      @(negedge clk_serial);
      k++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk_serial);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int run;
    bit dropped;
    int k;
    s_if.s_valid   = 1'b0;
    s_if.s_data    = '0;
    s_if_w.s_valid = 1'b0;
    s_if_w.s_data  = 8'h5A;

    // Reset state
    reset_n = 1'b0;
    repeat (2) @(negedge clk_serial);
    chk("rst_s_ready", 32'(s_if.s_ready), 32'd0);
    chk("rst_pulse", 32'(pulse), 32'd0);
    chk("rst_p", 32'(p), 32'd0);
    chk("rst_n", 32'(n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fc", 32'(fc), 32'd0);
    chk("rst_w_s_ready", 32'(s_if_w.s_ready), 32'd0);
    chk("rst_w_idle", {28'd0, pulse_w, p_w, n_w, busy_w}, 32'b0010);
    chk("rst_w_fc", 32'(fc_w), 32'd0);
    reset_n = 1'b1;
    @(negedge clk_serial);
    chk("post_rst_s_ready", 32'(s_if.s_ready), 32'd1);

    // Single word A5: latency and bit pattern
    pulse_cyc.delete();
    send(8'hA5);
    drain();
    chk("t1_pulses", 32'(pulse_cyc.size()), 32'd1);
    if (pulse_cyc.size() > 0) chk("t1_latency", 32'(pulse_cyc[0] - last_xfer), 32'd1);
    chk("t1_fc", 32'(fc), 32'd1);

    // Back-to-back words: minimum frame period
    pulse_cyc.delete();
    send(8'h3C);
    send(8'hFF);
    send(8'h00);
    drain();
    chk("t2_pulses", 32'(pulse_cyc.size()), 32'd3);
    if (pulse_cyc.size() == 3) begin
      chk("t2_period_1", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'(W + 2));
      chk("t2_period_2", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'(W + 2));
    end
    chk("t2_fc", 32'(fc), 32'd4);

    // Idle: no pulses, line parked
    pulse_cyc.delete();
    repeat (20) @(negedge clk_serial);
    chk("t6_pulses", 32'(pulse_cyc.size()), 32'd0);

    // Continuous valid with random data
    run = 0;
    dropped = 1'b0;
    for (int i = 0; i < 100; i++) begin
      s_if.s_data  = W'($urandom);
      s_if.s_valid = 1'b1;
      k = 0;
      while (!s_if.s_ready && k < 4 * W) begin
        dropped = 1'b1;
        @(negedge clk_serial);
        k++;
      end
      if (!s_if.s_ready) begin
        chk("t3_timeout", 32'(s_if.s_ready), 32'd1);
      end else begin
        if (!dropped) run++;
        exp_q.push_back(s_if.s_data);
      end
      @(negedge clk_serial);
    end
    s_if.s_valid = 1'b0;
    drain();
    chk("t3_accept_before_full", 32'(run), 32'(BUF_DEPTH + 1));
    chk("t3_fc", 32'(fc), 32'd104);

    // Reset during bit 3 of a frame
    @(negedge clk_serial);
    #2 reset_n = 1'b0;
    @(negedge clk_serial);
    reset_n = 1'b1;
    @(negedge clk_serial);
    chk("t4_fc_start", 32'(fc), 32'd0);
    send(8'h5F);
    chk("t4_pulse", 32'(pulse), 32'd1);
    repeat (W - 3) @(negedge clk_serial);
    chk("t4_bit3", 32'(p), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t4_abort_p", 32'(p), 32'd0);
    chk("t4_abort_n", 32'(n), 32'd1);
    chk("t4_abort_busy", 32'(busy), 32'd0);
    chk("t4_abort_fc", 32'(fc), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk_serial);
    reset_n = 1'b1;
    @(negedge clk_serial);
    send(8'h96);
    drain();
    chk("t4_fc_after", 32'(fc), 32'd1);

    // Frame counter wrap on the narrow instance
    s_if_w.s_valid = 1'b1;
    k = 0;
    while (fc_w != WCW'(7) && k < 200) begin
      @(negedge clk_serial);
      chk("w_n_is_not_p", 32'(n_w), 32'(!p_w));
      k++;
    end
    chk("t5_reach_max", 32'(fc_w), 32'd7);
    k = 0;
    while (fc_w == WCW'(7) && k < 4 * W) begin
      @(negedge clk_serial);
      k++;
    end
    chk("t5_wrap", 32'(fc_w), 32'd0);
    s_if_w.s_valid = 1'b0;

    repeat (4) @(negedge clk_serial);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
